// File: rtl/rv_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module      : rv_instr_encoder
//  Description : Sequential RV32I instruction encoder. Accepts field-level
//                requests over valid/ready, emits packed instruction words
//                tagged with a running byte address; expands LI into
//                lui+addi when a single addi cannot hold the value.
//  Revision    : 1.0 - initial release
// ============================================================================
module rv_instr_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_kind,
  input  logic [2:0]  req_funct3,
  input  logic        req_funct75,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        err
);

  localparam logic [6:0] C_OP_R      = 7'b0110011;
  localparam logic [6:0] C_OP_IALU   = 7'b0010011;
  localparam logic [6:0] C_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] C_OP_STORE  = 7'b0100011;
  localparam logic [6:0] C_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] C_OP_LUI    = 7'b0110111;
  localparam logic [6:0] C_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] C_OP_JAL    = 7'b1101111;
  localparam logic [6:0] C_OP_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_HOLD_LI = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [31:0] pend_q, pend_d;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  // Encoder results for the request currently on the input port
  logic        enc_err;
  logic        enc_two;
  logic [31:0] enc_w0;
  logic [31:0] enc_w1;

  logic        fits12, fits13, fits21, is_shift;
  logic [19:0] lui_hi;

  // Encode the presented request fields into one or two words plus an error flag
  always_comb begin
    // Signed range tests: the bits above the field must all equal the sign bit
    fits12   = (&req_imm[31:11]) | ~(|req_imm[31:11]);
    fits13   = (&req_imm[31:12]) | ~(|req_imm[31:12]);
    fits21   = (&req_imm[31:20]) | ~(|req_imm[31:20]);
    is_shift = (req_funct3 == 3'b001) || (req_funct3 == 3'b101);
    // addi sign-extends its 12-bit immediate, so the upper part absorbs bit 11
    lui_hi   = req_imm[31:12] + {19'd0, req_imm[11]};
    enc_err  = 1'b0;
    enc_two  = 1'b0;
    enc_w0   = 32'h0;
    enc_w1   = 32'h0;
    case (req_kind)
      4'd0: enc_w0 = {1'b0, req_funct75, 5'b00000, req_rs2, req_rs1, req_funct3, req_rd, C_OP_R};
      4'd1: begin
        if (is_shift) begin
          enc_err = |req_imm[31:5];
          enc_w0  = {1'b0, req_funct75, 5'b00000, req_imm[4:0], req_rs1, req_funct3, req_rd, C_OP_IALU};
        end else begin
          enc_err = ~fits12;
          enc_w0  = {req_imm[11:0], req_rs1, req_funct3, req_rd, C_OP_IALU};
        end
      end
      4'd2: begin
        enc_err = ~fits12;
        enc_w0  = {req_imm[11:0], req_rs1, req_funct3, req_rd, C_OP_LOAD};
      end
      4'd3: begin
        enc_err = ~fits12;
        enc_w0  = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], C_OP_STORE};
      end
      4'd4: begin
        enc_err = ~fits13 | req_imm[0];
        enc_w0  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                   req_imm[4:1], req_imm[11], C_OP_BRANCH};
      end
      4'd5: enc_w0 = {req_imm[31:12], req_rd, C_OP_LUI};
      4'd6: enc_w0 = {req_imm[31:12], req_rd, C_OP_AUIPC};
      4'd7: begin
        enc_err = ~fits21 | req_imm[0];
        enc_w0  = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, C_OP_JAL};
      end
      4'd8: begin
        enc_err = ~fits12;
        enc_w0  = {req_imm[11:0], req_rs1, 3'b000, req_rd, C_OP_JALR};
      end
      4'd9: begin
        if (fits12) begin
          enc_w0 = {req_imm[11:0], 5'd0, 3'b000, req_rd, C_OP_IALU};
        end else begin
          enc_w0  = {lui_hi, req_rd, C_OP_LUI};
          enc_w1  = {req_imm[11:0], req_rd, 3'b000, req_rd, C_OP_IALU};
          enc_two = |req_imm[11:0];
        end
      end
      default: enc_err = 1'b1;
    endcase
  end

  // Handshake FSM: next state, word/address updates and error pulse
  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    pend_d    = pend_q;
    addr_d    = addr_q;
    err_d     = 1'b0;
    req_ready = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (enc_err) begin
            err_d = 1'b1;
          end else begin
            word_d  = enc_w0;
            pend_d  = enc_w1;
            state_d = enc_two ? S_HOLD_LI : S_HOLD;
          end
        end
      end
      S_HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          addr_d  = addr_q + 32'd4;
          state_d = S_IDLE;
        end
      end
      S_HOLD_LI: begin
        out_valid = 1'b1;
        if (out_ready) begin
          addr_d  = addr_q + 32'd4;
          word_d  = pend_q;
          state_d = S_HOLD;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset discards any pending word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      word_q  <= 32'h0;
      pend_q  <= 32'h0;
      addr_q  <= BASE_ADDR;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  assign out_word = word_q;
  assign out_addr = addr_q;
  assign err      = err_q;

endmodule
`default_nettype wire

// File: doc/rv_instr_encoder.md
# rv_instr_encoder

Sequential RV32I instruction encoder: the inverse of the core's opcode/funct3/funct7[5] control decode. Accepts field-level instruction requests over a valid/ready handshake and emits packed 32-bit instruction words, each tagged with a running instruction-memory byte address. Sits between the boot/self-test program sequencer and the instruction-memory write port. Expands the `LI` pseudo-instruction into `lui`+`addi` when one word is not enough.

## Interface
- `BASE_ADDR`, 32'h0000_0000, byte address of the first emitted word.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  encoder can accept a request.
- `req_kind`  in  4  0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 LUI, 6 AUIPC, 7 JAL, 8 JALR, 9 LI; 10-15 invalid.
- `req_funct3`  in  3  funct3 field (ignored for LUI/AUIPC/JAL/LI; forced 000 for JALR).
- `req_funct75`  in  1  instr[30] for R and for I-ALU shifts (funct3 001/101).
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register indices.
- `req_imm`  in  32  immediate/offset, two's complement (upper-immediate value for LUI/AUIPC, i.e. instr[31:12] = imm[31:12]).
- `out_valid`  out  1  `out_word` valid.
- `out_ready`  in  1  consumer accepts word.
- `out_word`  out  32  encoded instruction.
- `out_addr`  out  32  byte address of `out_word`.
- `err`  out  1  one-cycle pulse: accepted request was rejected.

## Operation
- Encodings (opcode in [6:0]): R {0,f75,00000,rs2,rs1,f3,rd,0110011}; I-ALU {imm[11:0],rs1,f3,rd,0010011}, except shifts use {0,f75,00000,imm[4:0]} as [31:20]; LOAD {imm[11:0],rs1,f3,rd,0000011}; STORE {imm[11:5],rs2,rs1,f3,imm[4:0],0100011}; BRANCH {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],1100011}; LUI/AUIPC {imm[31:12],rd,0110111/0010111}; JAL {imm[20],imm[10:1],imm[11],imm[19:12],rd,1101111}; JALR {imm[11:0],rs1,000,rd,1100111}.
- Range checks, errors: I-ALU non-shift/LOAD/STORE/JALR need imm in [-2048,2047]; shifts need imm in [0,31]; BRANCH needs even imm in [-4096,4094]; JAL needs even imm in [-2^20,2^20-2]; kind 10-15 always error. LUI/AUIPC/R/LI never error.
- LI: if imm in [-2048,2047], emit one `addi rd,x0,imm`. Otherwise emit `lui rd,hi` with hi = imm[31:12] + imm[11] (mod 2^20), then `addi rd,rd,imm[11:0]`. Omit the addi when imm[11:0] == 0.
- FSM states: IDLE, HOLD (one word presented), HOLD_LI (lui presented, addi pending).
  - IDLE: `req_ready`=1. On `req_valid`, the request is accepted. A valid one-word result goes to HOLD. A two-word LI goes to HOLD_LI. An error pulses `err` next cycle, emits nothing and stays in IDLE.
  - HOLD: `out_valid`=1. On `out_ready`, go to IDLE.
  - HOLD_LI: `out_valid`=1 with the lui word. On `out_ready`, load the addi word and go to HOLD.
- `out_addr` increments by 4 (mod 2^32) on every out handshake. Errors never consume an address.
- Request fields are captured at acceptance. Later changes to the inputs have no effect.

## Timing
- Reset values: state IDLE, `req_ready`=1 (combinational from IDLE), `out_valid`=0, `out_word`=0, `out_addr`=BASE_ADDR, `err`=0.
- Latency: a request accepted on edge N gives `out_valid`=1 from cycle N+1, or `err`=1 for exactly cycle N+1.
- `req_ready`=0 in HOLD/HOLD_LI. Maximum throughput is one word per 2 cycles.
- LI second word: valid the cycle after the first word's handshake, at the first word's address+4.
- `out_word`/`out_addr` stay stable while `out_valid`=1 and `out_ready`=0.
- Reset asserted mid-operation (including between LI words): immediately drop `out_valid`, discard pending words, and restore `out_addr` to BASE_ADDR.

## Test plan
- R add/sub: kind 0, rd 3, rs1 1, rs2 2, f3 0, f75 0 -> 0x002081B3 at BASE_ADDR. Same with f75 1 -> 0x402081B3 at BASE_ADDR+4.
- LI large: rd 5, imm 0x12345678 -> 0x123452B7, then 0x67828293 at consecutive addresses. With imm 0x00000800 -> 0x000012B7, then 0x80028293. With imm 0x00005000 -> single 0x000052B7.
- Backpressure: BRANCH beq, rs1 1, rs2 2, imm -4, `out_ready` low for 5 cycles -> 0xFE208EE3 held stable and `req_ready`=0 throughout, then one handshake.
- Errors: BRANCH imm 3, I-ALU imm 2048, kind 12 -> each gives `err` for one cycle, no `out_valid`, and `out_addr` unchanged.
- JAL rd 1, imm 8 -> 0x008000EF. JALR rd 0, rs1 1, imm 0 -> 0x00008067.
- Reset between LI words -> `out_valid` 0 asynchronously, and after release `out_addr`=BASE_ADDR with no addi emitted.
